// File: rtl/tis_stack_node.sv
// tis_stack_node
// LIFO of signed words shared by NPORTS neighbouring TIS cores. Each port has
// its own push and pop request/acknowledge pair; independent round-robin
// pointers pick one pusher and one popper per cycle. Pushed values are clamped
// to +/-MAXVAL before they are stored.
//
// Ports
//   clk      : single clock, all state updates on the rising edge
//   rst      : synchronous active-high reset
//   wr_req   : per-port push request
//   wr_data  : push operands, port i at [i*WIDTH +: WIDTH]
//   wr_ack   : one-hot push grant (zero when no push this cycle)
//   rd_req   : per-port pop request
//   rd_ack   : one-hot pop grant (zero when no pop this cycle)
//   rd_data  : current top of stack, 0 when empty
//   count    : number of words held
//   empty    : count == 0
//   full     : count == DEPTH
module tis_stack_node #(
  parameter int WIDTH  = 11,
  parameter int DEPTH  = 15,
  parameter int NPORTS = 4,
  parameter int MAXVAL = 999,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        wr_req,
  input  logic [NPORTS*WIDTH-1:0]  wr_data,
  output logic [NPORTS-1:0]        wr_ack,
  input  logic [NPORTS-1:0]        rd_req,
  output logic [NPORTS-1:0]        rd_ack,
  output logic [WIDTH-1:0]         rd_data,
  output logic [CW-1:0]            count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic signed [WIDTH-1:0] SAT_HI = WIDTH'(MAXVAL);
  localparam logic signed [WIDTH-1:0] SAT_LO = -SAT_HI;

  logic signed [WIDTH-1:0] mem_reg [DEPTH];
  logic [CW-1:0]           count_reg;
  logic [PW-1:0]           rd_ptr_reg;
  logic [PW-1:0]           wr_ptr_reg;
  logic [PW-1:0]           rd_ptr_next;
  logic [PW-1:0]           wr_ptr_next;

  // Per-port saturated push operand.
  logic signed [WIDTH-1:0] port_sat [NPORTS];

  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_sat
      logic signed [WIDTH-1:0] raw;
      assign raw = wr_data[gi*WIDTH +: WIDTH];
      assign port_sat[gi] = (raw > SAT_HI) ? SAT_HI :
                            (raw < SAT_LO) ? SAT_LO : raw;
    end
  endgenerate

  // Round-robin pick: first requester at or after ptr, wrapping at NPORTS.
  // Returns {found, winner}.
  function automatic logic [PW:0] rr_pick(input logic [NPORTS-1:0] req,
                                          input logic [PW-1:0]     ptr);
    logic          found;
    logic [PW-1:0] win;
    logic [PW:0]   scan;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NPORTS; i++) begin
      scan = {1'b0, ptr} + (PW+1)'(i);
      if (scan >= (PW+1)'(NPORTS)) begin
        scan = scan - (PW+1)'(NPORTS);
      end
      if (!found && req[scan[PW-1:0]]) begin
        found = 1'b1;
        win   = scan[PW-1:0];
      end
    end
    return {found, win};
  endfunction

  logic          rd_found;
  logic          wr_found;
  logic [PW-1:0] rd_win;
  logic [PW-1:0] wr_win;
  logic          pop_grant;
  logic          push_grant;
  logic [CW-1:0] count_m1;
  logic [AW-1:0] top_idx;
  logic [AW-1:0] free_idx;
  logic signed [WIDTH-1:0] push_val;

  always_comb begin
    {rd_found, rd_win} = rr_pick(rd_req, rd_ptr_reg);
    {wr_found, wr_win} = rr_pick(wr_req, wr_ptr_reg);
  end

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CW'(DEPTH));
  assign count = count_reg;

  // Pops never look at write traffic; a push into a full stack rides on a
  // pop granted in the same cycle (replace-top), which is the only
  // read-to-write dependency.
  assign pop_grant  = !rst && rd_found && !empty;
  assign push_grant = !rst && wr_found && (!full || pop_grant);

  assign rd_ack = pop_grant  ? (NPORTS'(1) << rd_win) : '0;
  assign wr_ack = push_grant ? (NPORTS'(1) << wr_win) : '0;

  assign count_m1 = count_reg - CW'(1);
  assign top_idx  = count_m1[AW-1:0];
  assign free_idx = count_reg[AW-1:0];
  assign push_val = port_sat[wr_win];

  assign rd_data = empty ? '0 : mem_reg[top_idx];

  assign rd_ptr_next = (rd_win == PW'(NPORTS - 1)) ? '0 : rd_win + PW'(1);
  assign wr_ptr_next = (wr_win == PW'(NPORTS - 1)) ? '0 : wr_win + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
    end else begin
      if (pop_grant) begin
        rd_ptr_reg <= rd_ptr_next;
      end
      if (push_grant) begin
        wr_ptr_reg <= wr_ptr_next;
      end
      // Simultaneous push and pop leaves the count unchanged.
      if (push_grant && !pop_grant) begin
        count_reg <= count_reg + CW'(1);
      end else if (pop_grant && !push_grant) begin
        count_reg <= count_m1;
      end
    end
  end

  // Contents need no reset: count gates everything visible.
  always_ff @(posedge clk) begin
    if (push_grant) begin
      if (pop_grant) begin
        mem_reg[top_idx] <= push_val;
      end else begin
        mem_reg[free_idx] <= push_val;
      end
    end
  end

endmodule

// File: tb/tb_tis_stack_node.sv
// Directed testbench for tis_stack_node with default parameters
// (WIDTH=11, DEPTH=15, NPORTS=4, MAXVAL=999).
module tb_tis_stack_node;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  wr_req;
  logic [43:0] wr_data;
  logic [3:0]  wr_ack;
  logic [3:0]  rd_req;
  logic [3:0]  rd_ack;
  logic [10:0] rd_data;
  logic [3:0]  count;
  logic        empty;
  logic        full;

  int errors = 0;
  int checks = 0;

  tis_stack_node dut (
    .clk     (clk),
    .rst     (rst),
    .wr_req  (wr_req),
    .wr_data (wr_data),
    .wr_ack  (wr_ack),
    .rd_req  (rd_req),
    .rd_ack  (rd_ack),
    .rd_data (rd_data),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled
  // 1 unit after that, well away from the next edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    wr_req  = '0;
    rd_req  = '0;
    wr_data = '0;
  endtask

  task automatic set_wdata(input int p, input logic [10:0] v);
    wr_data[p*11 +: 11] = v;
  endtask

  task automatic push_one(input int p, input logic [10:0] v);
    idle();
    set_wdata(p, v);
    wr_req[p] = 1'b1;
    tick();
    idle();
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst    = 1'b1;
    wr_req = 4'hF;
    rd_req = 4'hF;
    #1;
    checks++; if (wr_ack !== 4'b0000) begin errors++; $display("FAIL rst_wr_ack got=%b exp=0000", wr_ack); end
    checks++; if (rd_ack !== 4'b0000) begin errors++; $display("FAIL rst_rd_ack got=%b exp=0000", rd_ack); end
    tick();
    tick();
    rst = 1'b0;
    idle();
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst_full got=%b exp=0", full); end
    checks++; if (rd_data !== 11'd0) begin errors++; $display("FAIL rst_rd_data got=%0d exp=0", $signed(rd_data)); end
    // First push from port 1.
    set_wdata(1, 11'd5);
    wr_req = 4'b0010;
    #1;
    checks++; if (wr_ack !== 4'b0010) begin errors++; $display("FAIL p1_wr_ack got=%b exp=0010", wr_ack); end
    checks++; if (rd_ack !== 4'b0000) begin errors++; $display("FAIL p1_rd_ack got=%b exp=0000", rd_ack); end
    tick();
    idle();
    #1;
    $display("push port1 value 5 -> count=%0d rd_data=%0d", count, $signed(rd_data));
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL p1_count got=%0d exp=1", count); end
    checks++; if (rd_data !== 11'd5) begin errors++; $display("FAIL p1_rd_data got=%0d exp=5", $signed(rd_data)); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL p1_empty got=%b exp=0", empty); end
  endtask

  task automatic test_saturation;
    do_reset();
    push_one(0, 11'(1000));
    push_one(2, 11'(-1023));
    #1;
    $display("push 1000 p0, -1023 p2 -> count=%0d top=%0d", count, $signed(rd_data));
    checks++; if (rd_data !== 11'(-999)) begin errors++; $display("FAIL sat_low got=%0d exp=-999", $signed(rd_data)); end
    checks++; if (count !== 4'd2) begin errors++; $display("FAIL sat_count2 got=%0d exp=2", count); end
    rd_req = 4'b0001;
    #1;
    checks++; if (rd_ack !== 4'b0001) begin errors++; $display("FAIL sat_rd_ack got=%b exp=0001", rd_ack); end
    tick();
    idle();
    #1;
    $display("pop p0 -> count=%0d top=%0d", count, $signed(rd_data));
    checks++; if (rd_data !== 11'(999)) begin errors++; $display("FAIL sat_high got=%0d exp=999", $signed(rd_data)); end
    checks++; if (count !== 4'd1) begin errors++; $display("FAIL sat_count1 got=%0d exp=1", count); end
  endtask

  task automatic test_fill;
    do_reset();
    for (int v = 1; v <= 15; v++) begin
      push_one(0, 11'(v));
    end
    #1;
    $display("filled 1..15 -> count=%0d full=%b", count, full);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b exp=1", full); end
    checks++; if (count !== 4'd15) begin errors++; $display("FAIL fill_count got=%0d exp=15", count); end
    set_wdata(0, 11'd77);
    wr_req = 4'b0001;
    #1;
    checks++; if (wr_ack !== 4'b0000) begin errors++; $display("FAIL full_hold_ack got=%b exp=0000", wr_ack); end
    tick();
    checks++; if (wr_ack !== 4'b0000) begin errors++; $display("FAIL full_hold_ack2 got=%b exp=0000", wr_ack); end
    checks++; if (count !== 4'd15) begin errors++; $display("FAIL full_hold_count got=%0d exp=15", count); end
    rd_req = 4'b1000;
    #1;
    $display("full replace: rd_ack=%b wr_ack=%b rd_data=%0d", rd_ack, wr_ack, $signed(rd_data));
    checks++; if (rd_ack !== 4'b1000) begin errors++; $display("FAIL full_rd_ack got=%b exp=1000", rd_ack); end
    checks++; if (rd_data !== 11'd15) begin errors++; $display("FAIL full_old_top got=%0d exp=15", $signed(rd_data)); end
    checks++; if (wr_ack !== 4'b0001) begin errors++; $display("FAIL full_wr_ack got=%b exp=0001", wr_ack); end
    tick();
    idle();
    #1;
    checks++; if (rd_data !== 11'd77) begin errors++; $display("FAIL full_new_top got=%0d exp=77", $signed(rd_data)); end
    checks++; if (count !== 4'd15) begin errors++; $display("FAIL full_count_after got=%0d exp=15", count); end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag_after got=%b exp=1", full); end
  endtask

  task automatic test_empty_pop_push;
    do_reset();
    rd_req = 4'b0001;
    wr_req = 4'b0100;
    set_wdata(2, 11'd9);
    #1;
    $display("empty pop+push: rd_ack=%b wr_ack=%b", rd_ack, wr_ack);
    checks++; if (rd_ack !== 4'b0000) begin errors++; $display("FAIL nobypass_rd_ack got=%b exp=0000", rd_ack); end
    checks++; if (wr_ack !== 4'b0100) begin errors++; $display("FAIL nobypass_wr_ack got=%b exp=0100", wr_ack); end
    tick();
    wr_req = 4'b0000;
    #1;
    checks++; if (rd_ack !== 4'b0001) begin errors++; $display("FAIL ep_rd_ack got=%b exp=0001", rd_ack); end
    checks++; if (rd_data !== 11'd9) begin errors++; $display("FAIL ep_rd_data got=%0d exp=9", $signed(rd_data)); end
    tick();
    idle();
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL ep_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ep_empty got=%b exp=1", empty); end
  endtask

  task automatic test_round_robin;
    logic [3:0]  exp_ack;
    logic [10:0] exp_val;
    do_reset();
    for (int p = 0; p < 4; p++) begin
      set_wdata(p, 11'(p));
    end
    wr_req = 4'hF;
    for (int i = 0; i < 8; i++) begin
      exp_ack = 4'(1 << (i % 4));
      #1;
      $display("rr push %0d: wr_ack=%b", i, wr_ack);
      checks++; if (wr_ack !== exp_ack) begin errors++; $display("FAIL rr_wr_ack[%0d] got=%b exp=%b", i, wr_ack, exp_ack); end
      tick();
    end
    idle();
    rd_req = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      exp_val = 11'(3 - (i % 4));
      #1;
      $display("rr pop %0d: rd_data=%0d rd_ack=%b", i, $signed(rd_data), rd_ack);
      checks++; if (rd_data !== exp_val) begin errors++; $display("FAIL rr_pop[%0d] got=%0d exp=%0d", i, $signed(rd_data), exp_val); end
      checks++; if (rd_ack !== 4'b0001) begin errors++; $display("FAIL rr_rd_ack[%0d] got=%b exp=0001", i, rd_ack); end
      tick();
    end
    idle();
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL rr_count got=%0d exp=0", count); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    for (int v = 10; v < 17; v++) begin
      push_one(1, 11'(v));
    end
    rd_req = 4'b0100;
    tick();
    idle();
    #1;
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL mid_pre_count got=%0d exp=6", count); end
    rst    = 1'b1;
    wr_req = 4'hF;
    rd_req = 4'hF;
    #1;
    checks++; if (wr_ack !== 4'b0000) begin errors++; $display("FAIL mid_rst_wr_ack got=%b exp=0000", wr_ack); end
    checks++; if (rd_ack !== 4'b0000) begin errors++; $display("FAIL mid_rst_rd_ack got=%b exp=0000", rd_ack); end
    tick();
    rst = 1'b0;
    #1;
    $display("after mid reset: count=%0d empty=%b wr_ack=%b rd_ack=%b", count, empty, wr_ack, rd_ack);
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL mid_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got=%b exp=1", empty); end
    checks++; if (rd_data !== 11'd0) begin errors++; $display("FAIL mid_rd_data got=%0d exp=0", $signed(rd_data)); end
    checks++; if (wr_ack !== 4'b0001) begin errors++; $display("FAIL mid_wr_ack got=%b exp=0001", wr_ack); end
    checks++; if (rd_ack !== 4'b0000) begin errors++; $display("FAIL mid_rd_ack0 got=%b exp=0000", rd_ack); end
    tick();
    checks++; if (rd_ack !== 4'b0001) begin errors++; $display("FAIL mid_rd_ack got=%b exp=0001", rd_ack); end
    checks++; if (wr_ack !== 4'b0010) begin errors++; $display("FAIL mid_wr_ack2 got=%b exp=0010", wr_ack); end
    tick();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_saturation();
    test_fill();
    test_empty_pop_push();
    test_round_robin();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without finishing");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tis_stack_node.md
# tis_stack_node

Parametrised stack-memory node for the TIS grid: a LIFO of signed words shared by NPORTS neighbouring execution cores. Any core can push to it or pop from it over per-port request/acknowledge channels. The node sits beside the `core` instances in the grid and takes their port traffic in place of a direct core-to-core link. Behaviour beyond the fixed two-core arrangement:
- configurable depth, word width and port count;
- round-robin arbitration;
- saturation of written values to the TIS range.

## Interface
Parameters:
- WIDTH, 11: word width, two's-complement signed
- DEPTH, 15: stack capacity in words (≥2)
- NPORTS, 4: number of neighbour ports (≥1); index 0..3 = up, left, right, down
- MAXVAL, 999: saturation magnitude; must satisfy MAXVAL ≤ 2^(WIDTH-1)-1
- CW, $clog2(DEPTH+1): count width (derived, not overridden)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wr_req  in  NPORTS  per-port push request
- wr_data  in  NPORTS*WIDTH  push operands; port i at [i*WIDTH +: WIDTH]
- wr_ack  out  NPORTS  push accepted this cycle (one-hot or zero)
- rd_req  in  NPORTS  per-port pop request
- rd_ack  out  NPORTS  pop served this cycle (one-hot or zero)
- rd_data  out  WIDTH  current top of stack; 0 when empty
- count  out  CW  words held
- empty  out  1  count == 0
- full  out  1  count == DEPTH

## Operation
- **Storage:** register array of DEPTH words plus stack pointer `count`. Top = entry count-1.
- **Transfers:** a transfer occurs on a rising edge where the corresponding ack is high. The requester holds req and data stable until acked; it may drop req without an ack, and nothing happens.
- **Pop grant:** issued when !empty and at least one rd_req is set. Exactly one rd_ack goes high. Independent of write activity.
- **Push grant:** issued when at least one wr_req is set and (!full or a pop is granted in the same cycle). Exactly one wr_ack goes high.
- **Arbitration:** separate round-robin pointers, rd_ptr and wr_ptr, each in 0..NPORTS-1.
  - The winner is the first requesting port at or after the pointer, wrapping at NPORTS.
  - After a granted transfer the pointer becomes winner+1 mod NPORTS.
  - The pointer is unchanged when no grant is issued.
- **Saturation on push:** values > MAXVAL are stored as MAXVAL; values < -MAXVAL are stored as -MAXVAL.
- **Single ops:**
  - Push only: write the saturated value to entry[count]; count+1.
  - Pop only: rd_data (the old top) is consumed; count-1.
- **Simultaneous pop and push:** the popper receives the old top. The new value overwrites entry[count-1]; count unchanged. This holds when full.
- **No bypass:** a push into an empty stack is not visible to a pop in the same cycle, so rd_ack stays 0 when empty.
- **Reset:**
  - Outputs: count=0, empty=1, full=0, rd_data=0, wr_ack=0, rd_ack=0.
  - rd_ptr=0, wr_ptr=0. Stack contents are don't-care.
  - Reset mid-transfer discards all contents and the pending transfer. Acks are 0 during any cycle with rst high.

## Timing
- wr_ack, rd_ack and rd_data are combinational from registered state and the current req inputs. There is no path from wr_req to rd_ack.
- wr_ack depends on rd_req through the full-and-pop rule. This is the only cross dependency; there is no loop.
- Latency:
  - A pushed value is visible on rd_data the cycle after its ack.
  - count, empty and full update on the edge that completes a transfer.
- Throughput: one push and one pop per cycle sustained, across any port mix.
- No req is ever starved. With all NPORTS requesting continuously, each port is served once every NPORTS grants.

## Test plan
- **Reset then push from port 1:** rst for 2 cycles, then wr_req=0010, data=5 → wr_ack=0010 in the same cycle. Next cycle count=1, rd_data=5, empty=0.
- **Saturation:** push 1000 from port 0, then -1023 from port 2 → rd_data=-999, then after a pop rd_data=999. count goes 2 then 1.
- **Fill to DEPTH=15:**
  - Push 1..15 → full=1.
  - A 16th push (value 77) with no rd_req gets wr_ack=0 and is held.
  - Assert rd_req on port 3 at the same time → rd_ack=1000 with rd_data=15, and wr_ack issued. Next cycle rd_data=77, count=15.
- **Empty pop with simultaneous push:** count=0, rd_req=0001, wr_req=0100, data=9 → rd_ack=0, wr_ack=0100. Next cycle rd_ack=0001 with rd_data=9, then count=0.
- **Round-robin fairness:** all four wr_req held for 8 cycles with data = port index → grant order 0,1,2,3,0,1,2,3. Popping 8 times returns 3,2,1,0,3,2,1,0.
- **Reset mid-operation:** count=6 with both push and pop requested; assert rst for 1 cycle → acks 0 during reset. count=0, empty=1 and rd_data=0 the next cycle. The next grant goes to port 0 for both reads and writes.
